spike_aer_encoder: RTL and testbench
====================================

# spike_aer_encoder

Converts the parallel per-cycle `post_spikes` vector of an `snn_layer` into a serial address-event (AER) stream of `{neuron address, timestamp}` words with a valid/ready handshake. It sits directly downstream of `snn_layer`. It buffers bursts in a small FIFO so that downstream consumers (logger, router, UART bridge) can stall without losing single-neuron events. Vectors that arrive while a previous vector is still being serialized are dropped and counted.

## Interface
Parameters:
- `NUM_NEURONS`, 8: width of the input spike vector (1..256).
- `ADDR_W`, `$clog2(NUM_NEURONS)` (min 1): width of the event address.
- `TS_W`, 16: width of the timestamp counter.
- `DEPTH`, 16: number of FIFO entries. Must be a power of 2, ≥2.

Ports:
- `clk`  in  1: single clock. All state is updated on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `spikes_in`  in  NUM_NEURONS: spike vector from `snn_layer.post_spikes`, sampled every cycle.
- `clr_stats`  in  1: synchronous clear of `overflow` and `drop_cnt`.
- `aer_valid`  out  1: head FIFO entry is valid.
- `aer_ready`  in  1: consumer accepts the head entry.
- `aer_addr`  out  ADDR_W: neuron index of the head event.
- `aer_ts`  out  TS_W: timestamp of the head event.
- `fifo_count`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `busy`  out  1: serializer holds unsent bits (`pending != 0`).
- `overflow`  out  1: sticky flag, set when any vector is dropped.
- `drop_cnt`  out  16: count of dropped vectors, saturates at 0xFFFF.

## Operation
- **Timestamp counter `ts`:** free-running, increments every cycle and wraps at 2^TS_W.
- **Capture registers:** `pending[NUM_NEURONS]` and `cap_ts[TS_W]`.
- **Push select:** `push_oh` is the lowest set bit of `pending`, qualified by `pend_nz && fifo_count < DEPTH`.
  - A full FIFO blocks the push even if a pop occurs in the same cycle.
  - On a push, the entry `{index(push_oh), cap_ts}` is written and `pending &= ~push_oh`.
- **Load condition:** `spikes_in != 0 && (pending & ~push_oh) == 0`.
  - On load: `pending <= spikes_in` and `cap_ts <= ts`.
  - This includes the cycle in which the last pending bit is pushed, so back-to-back vectors lose no cycle.
- **Drop condition:** `spikes_in != 0` and the load condition is false.
  - The whole vector is discarded.
  - `overflow <= 1` and `drop_cnt` increments (saturating).
- **Zero input:** `spikes_in == 0` has no effect on capture.
- **Ordering:** events leave in capture order, and within a vector in ascending neuron index.
- **FIFO:**
  - Head is read combinationally: `aer_valid = (fifo_count != 0)`.
  - A pop occurs when `aer_valid && aer_ready`.
  - Simultaneous push and pop on a non-full FIFO leaves `fifo_count` unchanged.
  - `aer_addr` and `aer_ts` must stay stable while `aer_valid && !aer_ready`.
- **`clr_stats`:** clears `overflow` and `drop_cnt`. If a drop occurs in the same cycle, the clear wins for `overflow` and `drop_cnt` ends at 1.
- **Reset (asserted at any time, including mid-serialization):** `pending` cleared, FIFO emptied, `ts=0`, `overflow=0`, `drop_cnt=0`. In-flight events are lost.

## Timing
- **Reset values:** `aer_valid=0`, `aer_addr=0`, `aer_ts=0`, `fifo_count=0`, `busy=0`, `overflow=0`, `drop_cnt=0`.
- **Latency:** a vector sampled at edge E0 sets `busy` after E0. Its first event is pushed at E1, and `aer_valid` rises after E1, i.e. 2 cycles.
- **Serialization rate:** a vector with k set bits needs k push cycles when the FIFO is not full.
- **Sustained rate:** one event per cycle when `aer_ready` is held high.
- **Timestamp value:** `aer_ts` equals the `ts` value visible during the sampling cycle. With `ts=0` in the first cycle after reset release, a vector sampled at cycle n carries `ts = n mod 2^TS_W`.

## Structure
- Add `AER_TS_W` and `AER_FIFO_DEPTH` default macros to the shared `lif_pkg.vh`, alongside `W`/`FX`.
- Sub-module `aer_sync_fifo`:
  - Parameters: `DATA_W`, `DEPTH`.
  - Behaviour: async active-high reset, combinational head read, count output.
  - Reused later by the AER router.
- Top level contains the timestamp counter, capture/drop logic, priority encoder and stats.

## Test plan
- **Single spike:** `spikes_in=8'h10` for one cycle at ts=5, `aer_ready=1` → exactly one event {addr=4, ts=5}; `aer_valid` rises 2 cycles after sampling.
- **Burst ordering:** `spikes_in=8'hA5` at ts=20 → events addr 0,2,5,7, all ts=20, in 4 consecutive cycles; `busy` low after the 4th push.
- **Back-to-back load:** `8'h01` then `8'h80` on consecutive cycles → both accepted (no drop), events {0,t} then {7,t+1}.
- **Drop:** `8'hFF`, then `8'h01` one cycle later → second vector dropped, `overflow=1`, `drop_cnt=1`; after `clr_stats`, both read 0.
- **Backpressure:** `aer_ready=0`, DEPTH=16, feed 3×`8'hFF` spaced 10 cycles → `fifo_count` stops at 16, `busy` stays high, outputs stable. Release ready → 24 events in order, no loss beyond drops counted.
- **Reset mid-operation:** assert `rst` while `fifo_count=5` and `busy=1` → all outputs at reset values immediately (async); no stale events after release.

Source files
------------

// File: rtl/spike_aer_encoder_pkg.sv
// Shared defaults and helpers for the spike-to-AER encoder and the AER FIFO.
package spike_aer_encoder_pkg;

    localparam int AER_TS_W       = 16;
    localparam int AER_FIFO_DEPTH = 16;
    localparam int DROP_CNT_W     = 16;

    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    // A single-neuron layer still needs a 1-bit address field.
    function automatic int addr_width(input int num_neurons);
        return (num_neurons > 1) ? $clog2(num_neurons) : 1;
    endfunction

endpackage

// File: rtl/aer_sync_fifo.sv
// Single-clock FIFO with a combinational head read and an occupancy count.
module aer_sync_fifo #(
    parameter  int DATA_W = 19,
    parameter  int DEPTH  = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              valid,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign valid = (count != '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign wr_ok = push && !full;
    assign rd_ok = pop && valid;

    // Storage is left unreset; the head is forced to zero while empty instead.
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Serialises per-cycle spike vectors into a timestamped address-event stream.
module spike_aer_encoder
    import spike_aer_encoder_pkg::*;
#(
    parameter  int NUM_NEURONS = 8,
    parameter  int ADDR_W      = addr_width(NUM_NEURONS),
    parameter  int TS_W        = AER_TS_W,
    parameter  int DEPTH       = AER_FIFO_DEPTH,
    localparam int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_NEURONS-1:0] spikes_in,
    input  logic                   clr_stats,
    output logic                   aer_valid,
    input  logic                   aer_ready,
    output logic [ADDR_W-1:0]      aer_addr,
    output logic [TS_W-1:0]        aer_ts,
    output logic [CNT_W-1:0]       fifo_count,
    output logic                   busy,
    output logic                   overflow,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    logic [TS_W-1:0]        ts;
    logic [TS_W-1:0]        cap_ts;
    logic [NUM_NEURONS-1:0] pending;
    logic [NUM_NEURONS-1:0] low_oh;
    logic [NUM_NEURONS-1:0] push_oh;
    logic [NUM_NEURONS-1:0] pend_rest;
    logic [ADDR_W-1:0]      push_idx;
    logic                   pend_nz;
    logic                   fifo_full;
    logic                   push;
    logic                   load;
    logic                   drop;

    always_comb begin
        low_oh   = '0;
        push_idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_oh    = '0;
                low_oh[i] = 1'b1;
                push_idx  = ADDR_W'(i);
            end
        end
    end

    assign pend_nz   = |pending;
    assign push      = pend_nz && !fifo_full;
    assign push_oh   = push ? low_oh : '0;
    assign pend_rest = pending & ~push_oh;

    // A new vector may load in the same cycle the last pending bit leaves.
    assign load = (|spikes_in) && (pend_rest == '0);
    assign drop = (|spikes_in) && !load;
    assign busy = pend_nz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts      <= '0;
            cap_ts  <= '0;
            pending <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (load) begin
                pending <= spikes_in;
                cap_ts  <= ts;
            end else begin
                pending <= pend_rest;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_stats) begin
            overflow <= 1'b0;
            drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != DROP_CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    aer_sync_fifo #(
        .DATA_W (ADDR_W + TS_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data ({push_idx, cap_ts}),
        .pop     (aer_ready),
        .rd_data ({aer_addr, aer_ts}),
        .valid   (aer_valid),
        .full    (fifo_full),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder with a queue-based reference model.
module tb_spike_aer_encoder;

    localparam int N     = 8;
    localparam int AW    = 3;
    localparam int TW    = 16;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  spikes_in = '0;
    logic          clr_stats = 1'b0;
    logic          aer_valid;
    logic          aer_ready = 1'b1;
    logic [AW-1:0] aer_addr;
    logic [TW-1:0] aer_ts;
    logic [CW-1:0] fifo_count;
    logic          busy;
    logic          overflow;
    logic [15:0]   drop_cnt;

    spike_aer_encoder #(.NUM_NEURONS(N), .TS_W(TW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .spikes_in  (spikes_in),
        .clr_stats  (clr_stats),
        .aer_valid  (aer_valid),
        .aer_ready  (aer_ready),
        .aer_addr   (aer_addr),
        .aer_ts     (aer_ts),
        .fifo_count (fifo_count),
        .busy       (busy),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: events waiting in the capture stage and in the FIFO, in order.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [TW-1:0] t;
    } ev_t;

    ev_t         pend_q[$];
    ev_t         fifo_q[$];
    logic [TW-1:0] m_ts   = '0;
    logic        m_ovf    = 1'b0;
    int          m_drop   = 0;

    bit m_pop, m_push, m_dropped;
    int m_rem;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q.delete();
            fifo_q.delete();
            m_ts   = '0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            m_pop     = (fifo_q.size() != 0) && aer_ready;
            m_push    = (pend_q.size() != 0) && (fifo_q.size() < DEPTH);
            m_rem     = pend_q.size() - (m_push ? 1 : 0);
            m_dropped = 1'b0;
            if (m_pop) void'(fifo_q.pop_front());
            if (m_push) fifo_q.push_back(pend_q.pop_front());
            if (spikes_in != '0) begin
                if (m_rem == 0) begin
                    for (int i = 0; i < N; i++)
                        if (spikes_in[i]) pend_q.push_back(ev_t'{a: AW'(i), t: m_ts});
                end else begin
                    m_dropped = 1'b1;
                end
            end
            if (clr_stats) begin
                m_ovf  = 1'b0;
                m_drop = m_dropped ? 1 : 0;
            end else if (m_dropped) begin
                m_ovf = 1'b1;
                if (m_drop < 16'hFFFF) m_drop++;
            end
            m_ts = m_ts + 1'b1;
        end
    end

    always @(negedge clk) begin
        check("valid", aer_valid, fifo_q.size() != 0);
        if (fifo_q.size() != 0) begin
            check("addr", aer_addr, fifo_q[0].a);
            check("ts", aer_ts, fifo_q[0].t);
        end
        check("count", fifo_count, fifo_q.size());
        check("busy", busy, pend_q.size() != 0);
        check("overflow", overflow, m_ovf);
        check("drop_cnt", drop_cnt, m_drop);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ts(input logic [TW-1:0] t);
        int k;
        k = 0;
        while (m_ts != t && k < 200) begin
            cyc();
            k++;
        end
        check("wait_ts_reached", m_ts, t);
    endtask

    logic [TW-1:0] t0;
    int            n_ev;
    logic [AW-1:0] burst_a [4];

    initial begin
        burst_a[0] = 3'd0; burst_a[1] = 3'd2; burst_a[2] = 3'd5; burst_a[3] = 3'd7;

        repeat (3) cyc();
        check("rst_valid", aer_valid, 0);
        check("rst_addr", aer_addr, 0);
        check("rst_ts", aer_ts, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        rst = 1'b0;

        // single spike at ts=5
        wait_ts(16'd5);
        spikes_in = 8'h10;
        cyc();
        spikes_in = '0;
        check("single_busy", busy, 1);
        check("single_valid_e0", aer_valid, 0);
        cyc();
        check("single_valid_e1", aer_valid, 1);
        check("single_addr", aer_addr, 4);
        check("single_ts", aer_ts, 5);
        cyc();
        check("single_done", aer_valid, 0);

        // burst ordering at ts=20
        wait_ts(16'd20);
        spikes_in = 8'hA5;
        cyc();
        spikes_in = '0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("burst_valid", aer_valid, 1);
            check("burst_addr", aer_addr, burst_a[k]);
            check("burst_ts", aer_ts, 20);
            check("burst_busy", busy, (k != 3));
        end
        cyc();
        check("burst_done", aer_valid, 0);

        // back-to-back vectors
        wait_ts(16'd40);
        spikes_in = 8'h01;
        cyc();
        spikes_in = 8'h80;
        cyc();
        spikes_in = '0;
        check("b2b_addr0", aer_addr, 0);
        check("b2b_ts0", aer_ts, 40);
        cyc();
        check("b2b_addr1", aer_addr, 7);
        check("b2b_ts1", aer_ts, 41);
        check("b2b_nodrop", drop_cnt, 0);
        cyc();

        // drop, then clear
        spikes_in = 8'hFF;
        cyc();
        spikes_in = 8'h01;
        cyc();
        spikes_in = '0;
        check("drop_ovf", overflow, 1);
        check("drop_cnt1", drop_cnt, 1);
        repeat (10) cyc();
        clr_stats = 1'b1;
        cyc();
        clr_stats = 1'b0;
        check("clr_ovf", overflow, 0);
        check("clr_cnt", drop_cnt, 0);

        // drop coinciding with clear
        spikes_in = 8'hFF;
        cyc();
        spikes_in = 8'h01;
        clr_stats = 1'b1;
        cyc();
        spikes_in = '0;
        clr_stats = 1'b0;
        check("clrdrop_ovf", overflow, 0);
        check("clrdrop_cnt", drop_cnt, 1);
        repeat (10) cyc();
        clr_stats = 1'b1;
        cyc();
        clr_stats = 1'b0;

        // backpressure: three full vectors, FIFO holds 16
        aer_ready = 1'b0;
        t0 = m_ts;
        for (int j = 0; j < 3; j++) begin
            spikes_in = 8'hFF;
            cyc();
            spikes_in = '0;
            repeat (9) cyc();
        end
        check("bp_count", fifo_count, 16);
        check("bp_busy", busy, 1);
        check("bp_addr", aer_addr, 0);
        check("bp_ts", aer_ts, t0);
        repeat (3) cyc();
        check("bp_stable_addr", aer_addr, 0);
        check("bp_stable_ts", aer_ts, t0);
        aer_ready = 1'b1;
        n_ev = 0;
        for (int i = 0; i < 40; i++) begin
            if (aer_valid) n_ev++;
            cyc();
        end
        check("bp_events", n_ev, 24);
        check("bp_nodrop", drop_cnt, 0);
        check("bp_empty", fifo_count, 0);

        // asynchronous reset mid-serialisation
        aer_ready = 1'b0;
        spikes_in = 8'hFF;
        cyc();
        spikes_in = '0;
        repeat (5) cyc();
        check("mid_count", fifo_count, 5);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("arst_valid", aer_valid, 0);
        check("arst_addr", aer_addr, 0);
        check("arst_ts", aer_ts, 0);
        check("arst_count", fifo_count, 0);
        check("arst_busy", busy, 0);
        check("arst_ovf", overflow, 0);
        check("arst_drop", drop_cnt, 0);
        repeat (2) cyc();
        rst = 1'b0;
        aer_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("post_rst_quiet", aer_valid, 0);
        end
        wait_ts(16'd9);
        spikes_in = 8'h02;
        cyc();
        spikes_in = '0;
        cyc();
        check("post_rst_addr", aer_addr, 1);
        check("post_rst_ts", aer_ts, 9);
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
